// File: rtl/lsu_pkg.sv
// Shared constants, FSM state encoding and instruction decode for the lsu
// load/store stage. The macro LSU_MISALIGN_TRAP_EN makes misaligned halfword
// and word accesses take the fault path instead of proceeding.
package lsu_pkg;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

`ifdef LSU_MISALIGN_TRAP_EN
  localparam bit MISALIGN_TRAP = 1'b1;
`else
  localparam bit MISALIGN_TRAP = 1'b0;
`endif

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // Classification of an accepted instruction.
  typedef struct packed {
    logic is_mem;    // goes to the memory port
    logic is_store;  // memory access is a write
    logic fault;     // answered immediately with a fault
  } dec_t;

  // Decide how an instruction is handled at accept time.
  function automatic dec_t decode(input logic [6:0] opcode,
                                  input logic [2:0] funct3,
                                  input logic [1:0] addr_lo);
    dec_t d;
    logic legal;
    logic misaligned;
    d     = '0;
    legal = 1'b0;
    // funct3[1:0] gives the access size for both loads and stores
    misaligned = ((funct3[1:0] == 2'b01) && addr_lo[0]) ||
                 ((funct3[1:0] == 2'b10) && (addr_lo != 2'b00));
    case (opcode)
      OP_LOAD:  legal = funct3 inside {F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU};
      OP_STORE: legal = funct3 inside {F3_SB, F3_SH, F3_SW};
      default:  legal = 1'b0;
    endcase
    if ((opcode == OP_LOAD) || (opcode == OP_STORE)) begin
      if (!legal || (MISALIGN_TRAP && misaligned)) begin
        d.fault = 1'b1;
      end else begin
        d.is_mem   = 1'b1;
        d.is_store = (opcode == OP_STORE);
      end
    end
    return d;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational byte-lane steering for stores (write strobes and replicated
// write data) and byte/halfword extraction with sign/zero extension for loads.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  i_funct3,
  input  logic [1:0]  i_addr_lo,
  input  logic [31:0] i_store_data,
  input  logic [31:0] i_rdata,
  output logic [3:0]  o_wstrb,
  output logic [31:0] o_wdata,
  output logic [31:0] o_load_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Store lane enables and replicated data, chosen by access size.
  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    o_wstrb = 4'b1111;
    o_wdata = i_store_data;
    case (i_funct3[1:0])
      2'b00: begin
        o_wstrb = 4'b0001 << i_addr_lo;
        o_wdata = {4{i_store_data[7:0]}};
      end
      2'b01: begin
        o_wstrb = 4'b0011 << {i_addr_lo[1], 1'b0};
        o_wdata = {2{i_store_data[15:0]}};
      end
      default: begin
        o_wstrb = 4'b1111;
        o_wdata = i_store_data;
      end
    endcase
  end

  // Pick the addressed byte/halfword out of the read word and extend it.
  always_comb begin
    w_byte = i_rdata[7:0];
    case (i_addr_lo)
      2'd0:    w_byte = i_rdata[7:0];
      2'd1:    w_byte = i_rdata[15:8];
      2'd2:    w_byte = i_rdata[23:16];
      default: w_byte = i_rdata[31:24];
    endcase
    // addr[0] is ignored for halfwords; the trap option catches it upstream
    w_half = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];
    case (i_funct3)
      F3_LB:   o_load_data = {{24{w_byte[7]}}, w_byte};
      F3_LH:   o_load_data = {{16{w_half[15]}}, w_half};
      F3_LBU:  o_load_data = {24'h0, w_byte};
      F3_LHU:  o_load_data = {16'h0, w_half};
      default: o_load_data = i_rdata;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// RV32I load/store stage: accepts one instruction from the ALU stage, runs
// an optional req/ack data-memory access with a WAIT_LIMIT-cycle timeout,
// and hands a single result to writeback over valid/ready.
// Optional macro LSU_MISALIGN_TRAP_EN: misaligned halfword/word accesses
// fault without touching memory.
module lsu
  import lsu_pkg::*;
#(
  parameter int WAIT_LIMIT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [6:0]  opcode,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  input  logic [4:0]  rd,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic [4:0]  out_rd,
  output logic        out_fault,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  localparam int CW = (WAIT_LIMIT > 1) ? $clog2(WAIT_LIMIT) : 1;
  localparam logic [CW-1:0] WAIT_LAST = CW'(WAIT_LIMIT - 1);

  state_t        r_state;
  state_t        w_next_state;
  logic          r_is_store;
  logic [2:0]    r_funct3;
  logic [31:0]   r_addr;
  logic [31:0]   r_store_data;
  logic [4:0]    r_rd;
  logic [CW-1:0] r_wait;
  logic [31:0]   r_out_data;
  logic [4:0]    r_out_rd;
  logic          r_out_fault;

  dec_t          w_dec;
  logic          w_accept;
  logic          w_timeout;
  logic [3:0]    w_wstrb;
  logic [31:0]   w_wdata;
  logic [31:0]   w_load_data;

  assign w_dec     = decode(opcode, funct3, addr[1:0]);
  assign w_accept  = in_valid && (r_state == ST_IDLE);
  assign w_timeout = (r_state == ST_REQ) && !mem_ack && (r_wait == WAIT_LAST);

  lsu_align u_align (
    .i_funct3     (r_funct3),
    .i_addr_lo    (r_addr[1:0]),
    .i_store_data (r_store_data),
    .i_rdata      (mem_rdata),
    .o_wstrb      (w_wstrb),
    .o_wdata      (w_wdata),
    .o_load_data  (w_load_data)
  );

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block ordering.
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next_state;
  end

  // Next-state logic and handshake/memory-port outputs.
  always_comb begin
    w_next_state = r_state;
    in_ready     = (r_state == ST_IDLE);
    out_valid    = (r_state == ST_RESP);
    mem_req      = (r_state == ST_REQ);
    mem_we       = 1'b0;
    mem_addr     = 32'h0;
    mem_wstrb    = 4'h0;
    mem_wdata    = 32'h0;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) w_next_state = w_dec.is_mem ? ST_REQ : ST_RESP;
      end
      ST_REQ: begin
        mem_addr = {r_addr[31:2], 2'b00};
        if (r_is_store) begin
          mem_we    = 1'b1;
          mem_wstrb = w_wstrb;
          mem_wdata = w_wdata;
        end
        if (mem_ack || w_timeout) w_next_state = ST_RESP;
      end
      ST_RESP: begin
        if (out_ready) w_next_state = ST_IDLE;
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  // Latch the instruction on accept, count wait cycles, build the result.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_is_store   <= 1'b0;
      r_funct3     <= 3'h0;
      r_addr       <= 32'h0;
      r_store_data <= 32'h0;
      r_rd         <= 5'h0;
      r_wait       <= '0;
      r_out_data   <= 32'h0;
      r_out_rd     <= 5'h0;
      r_out_fault  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_is_store   <= w_dec.is_store;
            r_funct3     <= funct3;
            r_addr       <= addr;
            r_store_data <= store_data;
            r_rd         <= rd;
            r_wait       <= '0;
            if (!w_dec.is_mem) begin
              // pass-through and immediate faults both report addr
              r_out_data  <= addr;
              r_out_rd    <= w_dec.fault ? 5'h0 : rd;
              r_out_fault <= w_dec.fault;
            end
          end
        end
        ST_REQ: begin
          if (mem_ack) begin
            r_out_data  <= r_is_store ? 32'h0 : w_load_data;
            r_out_rd    <= r_is_store ? 5'h0 : r_rd;
            r_out_fault <= 1'b0;
          end else if (w_timeout) begin
            r_out_data  <= r_addr;
            r_out_rd    <= 5'h0;
            r_out_fault <= 1'b1;
          end else begin
            r_wait <= r_wait + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign out_data  = r_out_data;
  assign out_rd    = r_out_rd;
  assign out_fault = r_out_fault;

endmodule

// File: tb/tb_lsu.sv
// Self-checking bench for lsu: a table of single-instruction vectors plus
// hand-written timeout, reset, backpressure and slow-ack sequences. Expected
// writeback results go into a scoreboard queue when an instruction is driven
// and are compared when out_valid is seen.
module tb_lsu;

  localparam logic [6:0] LOAD  = 7'b0000011;
  localparam logic [6:0] STORE = 7'b0100011;
  localparam logic [6:0] ALU   = 7'b0110011;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] store_data;
  logic [4:0]  rd;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [4:0]  out_rd;
  logic        out_fault;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  lsu #(.WAIT_LIMIT(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .opcode     (opcode),
    .funct3     (funct3),
    .addr       (addr),
    .store_data (store_data),
    .rd         (rd),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_rd     (out_rd),
    .out_fault  (out_fault),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wstrb  (mem_wstrb),
    .mem_wdata  (mem_wdata),
    .mem_ack    (mem_ack),
    .mem_rdata  (mem_rdata)
  );

  typedef struct {
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] sd;
    logic [4:0]  r;
    logic [31:0] rdata;
    logic        exp_mem;
    logic [31:0] exp_maddr;
    logic        exp_we;
    logic [3:0]  exp_wstrb;
    logic [31:0] exp_wdata;
    logic [31:0] exp_data;
    logic [4:0]  exp_rd;
    logic        exp_fault;
  } vec_t;

  typedef struct {
    logic [31:0] data;
    logic [4:0]  r;
    logic        fault;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;
  localparam int NV = 14;
  vec_t vecs[NV];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [6:0] op, input logic [2:0] f3,
                              input logic [31:0] a, input logic [31:0] sd,
                              input logic [4:0] r, input logic [31:0] rdata,
                              input logic m, input logic [31:0] maddr,
                              input logic we, input logic [3:0] ws,
                              input logic [31:0] wd, input logic [31:0] d,
                              input logic [4:0] er, input logic f);
    vec_t v;
    v.op = op; v.f3 = f3; v.a = a; v.sd = sd; v.r = r; v.rdata = rdata;
    v.exp_mem = m; v.exp_maddr = maddr; v.exp_we = we; v.exp_wstrb = ws;
    v.exp_wdata = wd; v.exp_data = d; v.exp_rd = er; v.exp_fault = f;
    return v;
  endfunction

  // Compare the current writeback outputs against the oldest expectation.
  task automatic pop_check(input string tag);
    exp_t e;
    n_cmp++;
    if (sb.size() == 0) begin
      n_err++;
      $display("FAIL %s scoreboard: got out_valid, expected no result", tag);
    end else begin
      n_cmp--;
      e = sb.pop_front();
      check({tag, " out_data"}, out_data, e.data);
      check({tag, " out_rd"}, 32'(out_rd), 32'(e.r));
      check({tag, " out_fault"}, 32'(out_fault), 32'(e.fault));
    end
  endtask

  task automatic drive(input logic [6:0] op, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] sd,
                       input logic [4:0] r);
    in_valid = 1'b1; opcode = op; funct3 = f3; addr = a; store_data = sd; rd = r;
  endtask

  // Apply one table vector with ack in the first REQ cycle.
  task automatic run_vec(input vec_t v, input int idx);
    string tag;
    exp_t e;
    tag = $sformatf("v%0d", idx);
    check({tag, " in_ready"}, 32'(in_ready), 32'd1);
    drive(v.op, v.f3, v.a, v.sd, v.r);
    e.data = v.exp_data; e.r = v.exp_rd; e.fault = v.exp_fault;
    sb.push_back(e);
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0;
    if (v.exp_mem) begin
      check({tag, " mem_req"}, 32'(mem_req), 32'd1);
      check({tag, " out_valid early"}, 32'(out_valid), 32'd0);
      check({tag, " mem_addr"}, mem_addr, v.exp_maddr);
      check({tag, " mem_we"}, 32'(mem_we), 32'(v.exp_we));
      if (v.exp_we) begin
        check({tag, " mem_wstrb"}, 32'(mem_wstrb), 32'(v.exp_wstrb));
        check({tag, " mem_wdata"}, mem_wdata, v.exp_wdata);
      end
      mem_ack = 1'b1; mem_rdata = v.rdata;
      @(posedge clk); @(negedge clk);
      mem_ack = 1'b0; mem_rdata = 32'h0;
      check({tag, " mem_req after ack"}, 32'(mem_req), 32'd0);
    end else begin
      check({tag, " mem_req"}, 32'(mem_req), 32'd0);
    end
    check({tag, " out_valid"}, 32'(out_valid), 32'd1);
    if (out_valid) pop_check(tag);
    @(posedge clk); @(negedge clk);
    check({tag, " out_valid drop"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    int cnt;
    exp_t e;
    rst = 1'b1; in_valid = 1'b0; opcode = '0; funct3 = '0; addr = '0;
    store_data = '0; rd = '0; out_ready = 1'b1; mem_ack = 1'b0; mem_rdata = '0;

    vecs[0]  = mk(LOAD,  3'b000, 32'h103, 0, 5'd5, 32'h80AABBCC, 1, 32'h100, 0, 0, 0, 32'hFFFFFF80, 5'd5, 0);
    vecs[1]  = mk(LOAD,  3'b100, 32'h101, 0, 5'd6, 32'h80AABBCC, 1, 32'h100, 0, 0, 0, 32'h000000BB, 5'd6, 0);
    vecs[2]  = mk(LOAD,  3'b001, 32'h102, 0, 5'd7, 32'h80AABBCC, 1, 32'h100, 0, 0, 0, 32'hFFFF80AA, 5'd7, 0);
    vecs[3]  = mk(LOAD,  3'b101, 32'h100, 0, 5'd8, 32'h1234F00D, 1, 32'h100, 0, 0, 0, 32'h0000F00D, 5'd8, 0);
    vecs[4]  = mk(LOAD,  3'b010, 32'h200, 0, 5'd9, 32'hDEADBEEF, 1, 32'h200, 0, 0, 0, 32'hDEADBEEF, 5'd9, 0);
    vecs[5]  = mk(STORE, 3'b000, 32'h301, 32'h000000A5, 5'd4, 0, 1, 32'h300, 1, 4'b0010, 32'hA5A5A5A5, 0, 0, 0);
    vecs[6]  = mk(STORE, 3'b001, 32'h202, 32'h0000BEEF, 5'd4, 0, 1, 32'h200, 1, 4'b1100, 32'hBEEFBEEF, 0, 0, 0);
    vecs[7]  = mk(STORE, 3'b010, 32'h400, 32'hCAFEF00D, 5'd4, 0, 1, 32'h400, 1, 4'b1111, 32'hCAFEF00D, 0, 0, 0);
    vecs[8]  = mk(ALU,   3'b000, 32'h12345678, 0, 5'd7, 0, 0, 0, 0, 0, 0, 32'h12345678, 5'd7, 0);
    vecs[9]  = mk(LOAD,  3'b011, 32'h55, 0, 5'd3, 0, 0, 0, 0, 0, 0, 32'h55, 0, 1);
    vecs[10] = mk(STORE, 3'b100, 32'h66, 32'h1, 5'd3, 0, 0, 0, 0, 0, 0, 32'h66, 0, 1);
`ifdef LSU_MISALIGN_TRAP_EN
    vecs[11] = mk(LOAD,  3'b010, 32'h1002, 0, 5'd2, 32'h11223344, 0, 0, 0, 0, 0, 32'h1002, 0, 1);
    vecs[12] = mk(STORE, 3'b001, 32'h203, 32'h00001234, 5'd2, 0, 0, 0, 0, 0, 0, 32'h203, 0, 1);
    vecs[13] = mk(LOAD,  3'b001, 32'h103, 0, 5'd2, 32'h80AABBCC, 0, 0, 0, 0, 0, 32'h103, 0, 1);
`else
    vecs[11] = mk(LOAD,  3'b010, 32'h1002, 0, 5'd2, 32'h11223344, 1, 32'h1000, 0, 0, 0, 32'h11223344, 5'd2, 0);
    vecs[12] = mk(STORE, 3'b001, 32'h203, 32'h00001234, 5'd2, 0, 1, 32'h200, 1, 4'b1100, 32'h12341234, 0, 0, 0);
    vecs[13] = mk(LOAD,  3'b001, 32'h103, 0, 5'd2, 32'h80AABBCC, 1, 32'h100, 0, 0, 0, 32'hFFFF80AA, 5'd2, 0);
`endif

    // Reset state.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst in_ready", 32'(in_ready), 32'd1);
    check("rst out_valid", 32'(out_valid), 32'd0);
    check("rst out_data", out_data, 32'd0);
    check("rst out_rd", 32'(out_rd), 32'd0);
    check("rst out_fault", 32'(out_fault), 32'd0);
    check("rst mem_req", 32'(mem_req), 32'd0);
    check("rst mem_we", 32'(mem_we), 32'd0);
    check("rst mem_addr", mem_addr, 32'd0);
    check("rst mem_wstrb", 32'(mem_wstrb), 32'd0);
    check("rst mem_wdata", mem_wdata, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < NV; i++) run_vec(vecs[i], i);

    // Timeout: ack never comes, mem_req must stay up exactly 16 cycles.
    drive(LOAD, 3'b010, 32'h500, 0, 5'd9);
    e.data = 32'h500; e.r = 5'd0; e.fault = 1'b1;
    sb.push_back(e);
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0;
    cnt = 0;
    for (int k = 0; k < 40 && mem_req; k++) begin
      cnt++;
      @(negedge clk);
    end
    check("timeout req cycles", 32'(cnt), 32'd16);
    check("timeout out_valid", 32'(out_valid), 32'd1);
    if (out_valid) pop_check("timeout");
    @(negedge clk);

    // Spurious ack while idle is ignored.
    mem_ack = 1'b1; mem_rdata = 32'hFFFFFFFF;
    @(negedge clk);
    mem_ack = 1'b0;
    check("idle ack out_valid", 32'(out_valid), 32'd0);
    check("idle ack in_ready", 32'(in_ready), 32'd1);

    // Slow ack: request held stable for three cycles.
    drive(LOAD, 3'b101, 32'h702, 0, 5'd11);
    e.data = 32'h0000ABCD; e.r = 5'd11; e.fault = 1'b0;
    sb.push_back(e);
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("slow req c%0d", k), 32'(mem_req), 32'd1);
      check($sformatf("slow addr c%0d", k), mem_addr, 32'h700);
      if (k < 2) @(negedge clk);
    end
    mem_ack = 1'b1; mem_rdata = 32'hABCD0000;
    @(negedge clk);
    mem_ack = 1'b0;
    check("slow out_valid", 32'(out_valid), 32'd1);
    if (out_valid) pop_check("slow");
    @(negedge clk);

    // Backpressure: result held, new instruction not accepted.
    out_ready = 1'b0;
    drive(ALU, 3'b000, 32'h0BADF00D, 0, 5'd3);
    e.data = 32'h0BADF00D; e.r = 5'd3; e.fault = 1'b0;
    sb.push_back(e);
    @(posedge clk); @(negedge clk);
    drive(ALU, 3'b000, 32'h00001111, 0, 5'd12);
    check("bp out_valid", 32'(out_valid), 32'd1);
    if (out_valid) pop_check("bp");
    repeat (2) @(negedge clk);
    check("bp held valid", 32'(out_valid), 32'd1);
    check("bp held data", out_data, 32'h0BADF00D);
    check("bp in_ready", 32'(in_ready), 32'd0);
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check("bp release valid", 32'(out_valid), 32'd0);
    check("bp release in_ready", 32'(in_ready), 32'd1);

    // Reset during REQ, then a late ack.
    drive(LOAD, 3'b010, 32'h600, 0, 5'd13);
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0;
    check("rstreq mem_req", 32'(mem_req), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    mem_ack = 1'b1; mem_rdata = 32'h55555555;
    check("rstreq mem_req drop", 32'(mem_req), 32'd0);
    check("rstreq out_valid", 32'(out_valid), 32'd0);
    check("rstreq in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    mem_ack = 1'b0;
    check("late ack out_valid", 32'(out_valid), 32'd0);
    check("late ack in_ready", 32'(in_ready), 32'd1);
    check("late ack mem_req", 32'(mem_req), 32'd0);
    n_cmp++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard drain: got %0d pending, expected 0", sb.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
